// File: rtl/usb_boot_sequencer.sv
// Safe warm-boot handoff: drain SPI/USB activity, detach D+ for a fixed time, then fire warm-boot.
// Optional drain timeout enabled by defining USB_BOOT_DRAIN_TIMEOUT_EN.
module usb_boot_sequencer #(
   parameter int unsigned CLK_PER_US       = 48,
   parameter int unsigned QUIET_CYCLES     = 16,
   parameter int unsigned DETACH_US        = 10000,
   parameter logic [1:0]  BOOT_IMAGE       = 2'b01,
   parameter int unsigned DRAIN_TIMEOUT_US = 1000
) (
   input  logic       clk_48mhz,
   input  logic       reset_n,
   input  logic       boot_req,
   input  logic       spi_cs,
   input  logic       usb_tx_en,
   output logic       usb_pu,
   output logic       busy,
   output logic [1:0] warmboot_s,
   output logic       warmboot_boot,
   output logic       drain_timeout
);

   localparam int unsigned US_MAX = (DETACH_US > DRAIN_TIMEOUT_US) ? DETACH_US : DRAIN_TIMEOUT_US;
   localparam int unsigned US_W   = $clog2(US_MAX + 1);
   localparam int unsigned PRE_W  = $clog2(CLK_PER_US);
   localparam int unsigned QC_W   = $clog2(QUIET_CYCLES + 1);

   localparam logic [PRE_W-1:0] PRE_LAST       = PRE_W'(CLK_PER_US - 1);
   localparam logic [US_W-1:0]  US_DETACH_LAST = US_W'(DETACH_US - 1);
   localparam logic [QC_W-1:0]  QC_LAST        = QC_W'(QUIET_CYCLES - 1);
`ifdef USB_BOOT_DRAIN_TIMEOUT_EN
   localparam logic [US_W-1:0]  US_DRAIN_LAST  = US_W'(DRAIN_TIMEOUT_US - 1);
`endif

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRAIN,
      ST_DETACH,
      ST_BOOT
   } state_t;

   state_t            state_q, state_d;
   logic [QC_W-1:0]   quiet_cnt_q, quiet_cnt_d;
   logic [PRE_W-1:0]  presc_q, presc_d;
   logic [US_W-1:0]   us_cnt_q, us_cnt_d;

   logic quiet;
   logic quiet_done;
   logic us_tick;

   assign quiet      = spi_cs && !usb_tx_en;
   assign quiet_done = quiet && (quiet_cnt_q == QC_LAST);
   assign us_tick    = (presc_q == PRE_LAST);

`ifdef USB_BOOT_DRAIN_TIMEOUT_EN
   logic timeout_set;
   logic drain_timeout_q;
`endif

   // NOTE: every variable written here gets a default first, so no latch can be inferred.
   always_comb begin
      state_d     = state_q;
      quiet_cnt_d = quiet_cnt_q;
      presc_d     = presc_q;
      us_cnt_d    = us_cnt_q;
`ifdef USB_BOOT_DRAIN_TIMEOUT_EN
      timeout_set = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (boot_req) begin
               state_d     = ST_DRAIN;
               quiet_cnt_d = '0;
               presc_d     = '0;
               us_cnt_d    = '0;
            end
         end

         ST_DRAIN: begin
            if (!quiet) begin
               quiet_cnt_d = '0;
            end else if (quiet_done) begin
               state_d = ST_DETACH;
            end else begin
               quiet_cnt_d = quiet_cnt_q + 1'b1;
            end
`ifdef USB_BOOT_DRAIN_TIMEOUT_EN
            presc_d = us_tick ? '0 : presc_q + 1'b1;
            if (us_tick) begin
               us_cnt_d = us_cnt_q + 1'b1;
            end
            // Quiet completion on the same edge wins, leaving the flag clear.
            if (us_tick && (us_cnt_q == US_DRAIN_LAST) && !quiet_done) begin
               state_d     = ST_DETACH;
               timeout_set = 1'b1;
            end
`endif
            if (state_d == ST_DETACH) begin
               quiet_cnt_d = '0;
               presc_d     = '0;
               us_cnt_d    = '0;
            end
         end

         ST_DETACH: begin
            presc_d = us_tick ? '0 : presc_q + 1'b1;
            if (us_tick) begin
               us_cnt_d = us_cnt_q + 1'b1;
               if (us_cnt_q == US_DETACH_LAST) begin
                  state_d = ST_BOOT;
               end
            end
         end

         ST_BOOT: begin
            state_d = ST_BOOT;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: outputs are decoded from the next state and registered, so they change on the
   // same edge as the state and carry no combinational path from the inputs.
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         quiet_cnt_q   <= '0;
         presc_q       <= '0;
         us_cnt_q      <= '0;
         usb_pu        <= 1'b1;
         busy          <= 1'b0;
         warmboot_s    <= 2'b00;
         warmboot_boot <= 1'b0;
      end else begin
         state_q       <= state_d;
         quiet_cnt_q   <= quiet_cnt_d;
         presc_q       <= presc_d;
         us_cnt_q      <= us_cnt_d;
         usb_pu        <= (state_d == ST_IDLE) || (state_d == ST_DRAIN);
         busy          <= (state_d != ST_IDLE);
         warmboot_s    <= ((state_d == ST_DETACH) || (state_d == ST_BOOT)) ? BOOT_IMAGE : 2'b00;
         warmboot_boot <= (state_d == ST_BOOT);
      end
   end

`ifdef USB_BOOT_DRAIN_TIMEOUT_EN
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         drain_timeout_q <= 1'b0;
      end else if (timeout_set) begin
         drain_timeout_q <= 1'b1;
      end
   end

   assign drain_timeout = drain_timeout_q;
`else
   assign drain_timeout = 1'b0;
`endif

endmodule
